// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - arbitrates the UART TX byte path between atomic pixel pairs and response bytes
// Pixels go out high byte first, with an optional sync byte at start of frame; responses get a bounded burst window.
module uart_tx_sched #(
    parameter int unsigned BURST     = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    output logic        rsp_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] pix_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        PIX_HI = 3'd2,
        PIX_LO = 3'd3,
        RSP    = 3'd4
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] pix_count_q, pix_count_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;

    logic grant_rsp;
    logic grant_pix;
    logic tx_fire;

    // A pending response only overtakes pixels once the burst window is used up.
    always_comb begin
        grant_rsp = rsp_valid && (!pix_valid || (burst_cnt_q == BURST_MAX));
        grant_pix = pix_valid && !grant_rsp;
        tx_fire   = tx_valid_q && tx_ready;
    end

    assign pix_ready = rst && (state_q == IDLE) && grant_pix;
    assign rsp_ready = rst && (state_q == IDLE) && grant_rsp;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != IDLE);
    assign pix_count = pix_count_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        pix_count_d = pix_count_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_pix) begin
                    hold_d     = pix_data;
                    tx_valid_d = 1'b1;
                    if (pix_sof) begin
                        state_d     = SYNC;
                        tx_data_d   = SYNC_BYTE;
                        pix_count_d = '0;
                    end else begin
                        state_d   = PIX_HI;
                        tx_data_d = pix_data[15:8];
                    end
                end else if (grant_rsp) begin
                    hold_d      = {8'h00, rsp_data};
                    state_d     = RSP;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = rsp_data;
                    burst_cnt_d = '0;
                end
            end
            SYNC: begin
                if (tx_fire) begin
                    state_d   = PIX_HI;
                    tx_data_d = hold_q[15:8];
                end
            end
            PIX_HI: begin
                if (tx_fire) begin
                    state_d   = PIX_LO;
                    tx_data_d = hold_q[7:0];
                end
            end
            PIX_LO: begin
                if (tx_fire) begin
                    state_d     = IDLE;
                    tx_valid_d  = 1'b0;
                    pix_count_d = pix_count_q + 16'd1;
                    if (burst_cnt_q < BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
            end
            RSP: begin
                if (tx_fire) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            pix_count_q <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            pix_count_q <= pix_count_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a transaction-level reference model
module tb_uart_tx_sched;

    localparam int         BURST     = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] pix_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic       preload_req = 1'b0;

    uart_tx_sched #(.BURST(BURST), .SYNC_BYTE(SYNC_BYTE)) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_ready(pix_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks bytes still owed by the current transaction rather than FSM states.
    initial begin
        int         m_rem;
        int         m_burst;
        bit         m_is_pix;
        logic [7:0] m_final;
        logic [7:0] m_last;
        logic [15:0] m_pix;
        bit         rsp_pri, gp, gr;
        m_rem = 0; m_burst = 0; m_is_pix = 0; m_final = 0; m_last = 0; m_pix = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_rem = 0; m_burst = 0; m_last = 0; m_pix = 0;
                exp_q.delete();
                chk("rst_pix_ready", 32'(pix_ready), 0);
                chk("rst_rsp_ready", 32'(rsp_ready), 0);
                chk("rst_tx_valid", 32'(tx_valid), 0);
                chk("rst_tx_data", 32'(tx_data), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_pix_count", 32'(pix_count), 0);
            end else begin
                if (preload_req) m_pix = 16'hFFFF;
                rsp_pri = rsp_valid && (!pix_valid || m_burst == BURST);
                gr = (m_rem == 0) && rsp_pri;
                gp = (m_rem == 0) && pix_valid && !rsp_pri;
                chk("pix_ready", 32'(pix_ready), 32'(gp));
                chk("rsp_ready", 32'(rsp_ready), 32'(gr));
                chk("tx_valid", 32'(tx_valid), 32'(m_rem != 0));
                chk("busy", 32'(busy), 32'(m_rem != 0));
                chk("pix_count", 32'(pix_count), 32'(m_pix));
                if (m_rem == 0) chk("tx_data_retained", 32'(tx_data), 32'(m_last));
                if (m_rem != 0) begin
                    if (tx_ready) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_last = m_final;
                            if (m_is_pix) begin
                                m_pix++;
                                if (m_burst < BURST) m_burst++;
                            end
                        end
                    end
                end else if (gp) begin
                    m_is_pix = 1;
                    m_final  = pix_data[7:0];
                    m_rem    = pix_sof ? 3 : 2;
                    if (pix_sof) begin
                        m_pix = 0;
                        exp_q.push_back(SYNC_BYTE);
                    end
                    exp_q.push_back(pix_data[15:8]);
                    exp_q.push_back(pix_data[7:0]);
                end else if (gr) begin
                    m_is_pix = 0;
                    m_final  = rsp_data;
                    m_rem    = 1;
                    m_burst  = 0;
                    exp_q.push_back(rsp_data);
                end
            end
        end
    end

    // Monitor: checks every presented byte against the scoreboard head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected act=%0h exp=none at %0t", tx_data, $time);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q[0]));
                    if (tx_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        pix_valid = 0; pix_sof = 0; pix_data = 0;
        rsp_valid = 0; rsp_data = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic send_pix(input logic [15:0] d, input logic sof);
        logic ok;
        ok = 0;
        pix_valid = 1; pix_data = d; pix_sof = sof;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = pix_ready;
        end
        @(posedge clk); #1;
        pix_valid = 0; pix_sof = 0;
        chk("pix_accept", 32'(ok), 1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = !busy && !tx_valid;
        end
        chk("idle_reached", 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   win0, win1, n_win, n_rsp;
        logic ok;
        rst = 0;
        tx_ready = 1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1;

        send_pix(16'h1234, 0);
        wait_idle();
        chk("pix_count_single", 32'(pix_count), 1);

        for (int i = 0; i < 4; i++) begin
            send_pix(16'($urandom), 0);
            wait_idle();
        end
        chk("pix_count_before_sof", 32'(pix_count), 5);
        send_pix(16'hBEEF, 1);
        wait_idle();
        chk("pix_count_after_sof", 32'(pix_count), 1);

        do_reset();
        win0 = -1; win1 = -1; n_win = 0; n_rsp = 0;
        pix_valid = 1; pix_data = 16'($urandom); rsp_valid = 1; rsp_data = 8'h4F;
        for (int c = 0; c < 400 && n_rsp < 2; c++) begin
            @(negedge clk);
            if (pix_ready) n_win++;
            if (rsp_ready) begin
                if (n_rsp == 0) win0 = n_win;
                else win1 = n_win;
                n_rsp++;
                n_win = 0;
            end
            @(posedge clk); #1;
            pix_data = 16'($urandom);
        end
        rsp_valid = 0;
        chk("burst_window_first", 32'(win0), 8);
        chk("burst_window_second", 32'(win1), 8);
        repeat (12) begin
            @(posedge clk); #1;
            pix_data = 16'($urandom);
        end
        pix_valid = 0;
        wait_idle();

        tx_ready = 0;
        send_pix(16'hA0B1, 0);
        rsp_valid = 1; rsp_data = 8'h5C;
        repeat (10) begin
            @(negedge clk);
            chk("stall_tx_valid", 32'(tx_valid), 1);
            chk("stall_tx_data", 32'(tx_data), 32'h00A0);
        end
        @(posedge clk); #1;
        tx_ready = 1;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = rsp_ready;
        end
        chk("stall_rsp_accept", 32'(ok), 1);
        @(posedge clk); #1;
        rsp_valid = 0;
        wait_idle();

        send_pix(16'h7788, 0);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("rst_async_tx_valid", 32'(tx_valid), 0);
        chk("rst_async_pix_count", 32'(pix_count), 0);
        chk("rst_async_busy", 32'(busy), 0);
        @(posedge clk); #1 rst = 1;
        send_pix(16'h0001, 0);
        wait_idle();
        chk("pix_count_after_rst", 32'(pix_count), 1);

        preload_req = 1;
        force dut.pix_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.pix_count_q;
        preload_req = 0;
        chk("pix_count_preload", 32'(pix_count), 32'hFFFF);
        send_pix(16'h5555, 0);
        wait_idle();
        chk("pix_count_wrap", 32'(pix_count), 0);

        for (int c = 0; c < 800; c++) begin
            pix_valid = ($urandom % 3) != 0;
            pix_sof   = ($urandom % 8) == 0;
            pix_data  = 16'($urandom);
            rsp_valid = ($urandom % 3) == 0;
            rsp_data  = 8'($urandom);
            tx_ready  = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        clear_inputs();
        tx_ready = 1;
        wait_idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
